// File: rtl/led_rate_ctrl.sv
// Rotating-LED control stage: button sync/debounce, speed select, prescaled step tick and direction.
// Define LED_RATE_DEBOUNCE_EN to build the full debouncer; otherwise the synchroniser output is used directly.
module led_rate_ctrl #(
   parameter int unsigned BASE_DIV  = 25_000_000,
   parameter int unsigned DIV_W     = 25,
   parameter int unsigned DB_CYCLES = 1_000_000,
   parameter int unsigned DB_W      = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_dir,
   input  logic       btn_speed,
   input  logic       enable,
   output logic       tick,
   output logic       rt,
   output logic [1:0] speed
);

   // Reject parameter sets whose counters cannot hold their terminal values.
   if (((BASE_DIV >> 3) < 2) ||
       (64'(BASE_DIV) - 64'd1 >= (64'd1 << DIV_W)) ||
       (DB_CYCLES < 1) ||
       (64'(DB_CYCLES) - 64'd1 >= (64'd1 << DB_W))) begin : g_param_chk
      $error("led_rate_ctrl: illegal parameter combination");
   end

   // Bit 0 = direction button, bit 1 = speed button.
   logic [1:0] btn_raw_c;
   logic [1:0] sync1_q;
   logic [1:0] sync2_q;
   logic [1:0] db_lvl_c;
   logic [1:0] db_prev_q;
   logic [1:0] press_c;
   logic       dir_press_c;
   logic       spd_press_c;

   assign btn_raw_c = {btn_speed, btn_dir};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw_c;
         sync2_q <= sync1_q;
      end
   end

`ifdef LED_RATE_DEBOUNCE_EN
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic [1:0]      db_lvl_q;
   logic [1:0]      db_lvl_d;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];

   // Accept a new level only after DB_CYCLES consecutive differing samples.
   always_comb begin
      db_lvl_d = db_lvl_q;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = db_cnt_q[i];
         if (sync2_q[i] == db_lvl_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            db_lvl_d[i] = sync2_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         db_lvl_q    <= '0;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
      end else begin
         db_lvl_q    <= db_lvl_d;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
      end
   end

   assign db_lvl_c = db_lvl_q;
`else
   assign db_lvl_c = sync2_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         db_prev_q <= '0;
      end else begin
         db_prev_q <= db_lvl_c;
      end
   end

   assign press_c     = db_lvl_c & ~db_prev_q;
   assign dir_press_c = press_c[0];
   assign spd_press_c = press_c[1];

   logic [DIV_W-1:0] cnt_q;
   logic [DIV_W-1:0] cnt_d;
   logic [DIV_W-1:0] tc_c;
   logic [1:0]       speed_q;
   logic [1:0]       speed_d;
   logic             tick_q;
   logic             tick_d;
   logic             rt_q;
   logic             rt_d;
   logic             pend_q;
   logic             pend_d;

   assign tc_c = DIV_W'(BASE_DIV >> speed_q) - DIV_W'(1);

   // A speed press restarts the period; rt only moves on the edge after a tick.
   always_comb begin
      cnt_d   = cnt_q;
      tick_d  = 1'b0;
      speed_d = speed_q;
      rt_d    = rt_q;
      pend_d  = pend_q;
      if (spd_press_c) begin
         speed_d = speed_q + 2'd1;
         cnt_d   = '0;
      end else if (enable) begin
         if (cnt_q == tc_c) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
      if (tick_q && pend_q) begin
         rt_d   = ~rt_q;
         pend_d = 1'b0;
      end
      if (dir_press_c) begin
         pend_d = ~pend_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         speed_q <= '0;
         tick_q  <= 1'b0;
         rt_q    <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         speed_q <= speed_d;
         tick_q  <= tick_d;
         rt_q    <= rt_d;
         pend_q  <= pend_d;
      end
   end

   assign tick  = tick_q;
   assign rt    = rt_q;
   assign speed = speed_q;

endmodule
